// File: rtl/video_timing_if.sv
// Raster timing bundle between the timing generator (master) and its consumers (slave).
// The consumer side owns the pacing inputs pix_en and run.
interface video_timing_if #(
    parameter int CW  = 12,
    parameter int FCW = 16
) ();
    logic           pix_en;
    logic           run;
    logic [CW-1:0]  pixel_x;
    logic [CW-1:0]  pixel_y;
    logic           hsync;
    logic           vsync;
    logic           hblank;
    logic           vblank;
    logic           video_on;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_count;
    logic           active;

    modport master (
        input  pix_en, run,
        output pixel_x, pixel_y, hsync, vsync, hblank, vblank, video_on,
               line_start, frame_start, frame_count, active
    );

    modport slave (
        output pix_en, run,
        input  pixel_x, pixel_y, hsync, vsync, hblank, vblank, video_on,
               line_start, frame_start, frame_count, active
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: coordinates, sync, blanking and line/frame strobes,
// paced by pix_en, with run/stop that only takes effect at a frame boundary.
module video_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 12,
    parameter int FCW       = 16
) (
    input  logic            pixel_clk,
    input  logic            reset,
    video_timing_if.master  vif
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Inclusive bounds keep every constant below the total, so nothing needs CW+1 bits.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS      = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS      = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_VISIBLE + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_VISIBLE + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  x_q, x_d, y_q, y_d;
    logic           hsync_q, hsync_d, vsync_q, vsync_d;
    logic           hblank_q, hblank_d, vblank_q, vblank_d;
    logic           video_on_q, video_on_d, active_q, active_d;
    logic           line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [FCW-1:0] fcount_q, fcount_d;

    logic [CW-1:0]  nx, ny;
    logic           load_pos, load_idle, at_last, h_blk, v_blk;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        video_on_d    = video_on_q;
        active_d      = active_q;
        fcount_d      = fcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        nx            = x_q;
        ny            = y_q;
        load_pos      = 1'b0;
        load_idle     = 1'b0;
        h_blk         = 1'b1;
        v_blk         = 1'b1;
        at_last       = (x_q == H_LAST) && (y_q == V_LAST);

        if (vif.pix_en) begin
            case (state_q)
                IDLE: begin
                    if (vif.run) begin
                        state_d  = RUN;
                        nx       = '0;
                        ny       = '0;
                        load_pos = 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if (state_q == DRAIN && at_last && !vif.run) begin
                        state_d   = IDLE;
                        load_idle = 1'b1;
                    end else begin
                        state_d  = vif.run ? RUN : DRAIN;
                        load_pos = 1'b1;
                        if (x_q == H_LAST) begin
                            nx = '0;
                            ny = (y_q == V_LAST) ? '0 : y_q + 1'b1;
                        end else begin
                            nx = x_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    load_idle = 1'b1;
                end
            endcase
        end

        if (load_pos) begin
            h_blk         = (nx >= H_VIS);
            v_blk         = (ny >= V_VIS);
            x_d           = nx;
            y_d           = ny;
            hsync_d       = ((nx >= HS_FIRST) && (nx <= HS_LAST)) ? HSYNC_POL : !HSYNC_POL;
            vsync_d       = ((ny >= VS_FIRST) && (ny <= VS_LAST)) ? VSYNC_POL : !VSYNC_POL;
            hblank_d      = h_blk;
            vblank_d      = v_blk;
            video_on_d    = !h_blk && !v_blk;
            active_d      = 1'b1;
            line_start_d  = (nx == '0);
            frame_start_d = (nx == '0) && (ny == '0);
            if ((nx == '0) && (ny == '0)) fcount_d = fcount_q + 1'b1;
        end

        // Leaving the raster: park on IDLE values, frame counter is kept.
        if (load_idle) begin
            x_d        = '0;
            y_d        = '0;
            hsync_d    = !HSYNC_POL;
            vsync_d    = !VSYNC_POL;
            hblank_d   = 1'b1;
            vblank_d   = 1'b1;
            video_on_d = 1'b0;
            active_d   = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= !HSYNC_POL;
            vsync_q       <= !VSYNC_POL;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            video_on_q    <= 1'b0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            fcount_q      <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            video_on_q    <= video_on_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            fcount_q      <= fcount_d;
        end
    end

    assign vif.pixel_x     = x_q;
    assign vif.pixel_y     = y_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.hblank      = hblank_q;
    assign vif.vblank      = vblank_q;
    assign vif.video_on    = video_on_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_count = fcount_q;
    assign vif.active      = active_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small 15x8 positive-polarity mode with a 2-bit frame counter
// and the default 800x525 mode, both driven from the same pacing inputs.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    video_timing_if #(.CW(12), .FCW(2))  ia ();
    video_timing_if #(.CW(12), .FCW(16)) ib ();

    video_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(12), .FCW(2)
    ) dut_a (.pixel_clk(clk), .reset(rst), .vif(ia));

    video_timing_gen dut_b (.pixel_clk(clk), .reset(rst), .vif(ib));

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        hs, vs, hb, vb, von, ls, fs, act;
        logic [15:0] fc;
    } exp_t;

    // Hand-computed mode constants; position is derived from a step count, not from counters.
    typedef struct packed {
        int ht, vt, hvis, hs_lo, hs_hi, vvis, vs_lo, vs_hi;
        bit hpol, vpol;
        int fmod;
        bit on, dr, ls, fs;
        int k, fc;
    } mdl_t;

    mdl_t ma, mb;
    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    function automatic mdl_t mstep(mdl_t m, bit pe, bit r, bit rs);
        int ft;
        ft   = m.ht * m.vt;
        m.ls = 1'b0;
        m.fs = 1'b0;
        if (rs) begin
            m.on = 1'b0; m.dr = 1'b0; m.k = 0; m.fc = 0;
        end else if (pe) begin
            if (!m.on) begin
                if (r) begin
                    m.on = 1'b1; m.dr = 1'b0; m.k = 0; m.fc = m.fc + 1; m.ls = 1'b1; m.fs = 1'b1;
                end
            end else if (m.dr && (m.k % ft) == ft - 1 && !r) begin
                m.on = 1'b0; m.k = 0;
            end else begin
                m.k  = m.k + 1;
                m.dr = !r;
                m.ls = (m.k % m.ht) == 0;
                m.fs = (m.k % ft) == 0;
                if (m.fs) m.fc = m.fc + 1;
            end
        end
        return m;
    endfunction

    function automatic exp_t mexp(mdl_t m);
        exp_t e;
        int x, y;
        x     = m.on ? m.k % m.ht : 0;
        y     = m.on ? (m.k / m.ht) % m.vt : 0;
        e.x   = 12'(x);
        e.y   = 12'(y);
        e.hb  = !m.on || (x >= m.hvis);
        e.vb  = !m.on || (y >= m.vvis);
        e.hs  = (m.on && x >= m.hs_lo && x <= m.hs_hi) ? m.hpol : !m.hpol;
        e.vs  = (m.on && y >= m.vs_lo && y <= m.vs_hi) ? m.vpol : !m.vpol;
        e.von = m.on && !e.hb && !e.vb;
        e.ls  = m.ls;
        e.fs  = m.fs;
        e.act = m.on;
        e.fc  = 16'(m.fc % m.fmod);
        return e;
    endfunction

    function automatic exp_t grab_a();
        exp_t g;
        g = '{ia.pixel_x, ia.pixel_y, ia.hsync, ia.vsync, ia.hblank, ia.vblank, ia.video_on,
              ia.line_start, ia.frame_start, ia.active, {14'd0, ia.frame_count}};
        return g;
    endfunction

    function automatic exp_t grab_b();
        exp_t g;
        g = '{ib.pixel_x, ib.pixel_y, ib.hsync, ib.vsync, ib.hblank, ib.vblank, ib.video_on,
              ib.line_start, ib.frame_start, ib.active, ib.frame_count};
        return g;
    endfunction

    // Monitor: one expected record per clock per DUT, compared just after the edge.
    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                g = grab_a();
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL small_mode cyc=%0d got=%h required=%h", cyc, g, e);
                end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                g = grab_b();
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL default_mode cyc=%0d got=%h required=%h", cyc, g, e);
                end
            end
        end
    end

    task automatic tick(input bit pe, input bit r, input bit rs);
        rst       = rs;
        ia.pix_en = pe;
        ia.run    = r;
        ib.pix_en = pe;
        ib.run    = r;
        ma = mstep(ma, pe, r, rs);
        mb = mstep(mb, pe, r, rs);
        qa.push_back(mexp(ma));
        qb.push_back(mexp(mb));
        cyc++;
        @(posedge clk);
        #3;
    endtask

    initial begin
        ma = '{ht: 15, vt: 8, hvis: 8, hs_lo: 10, hs_hi: 12, vvis: 4, vs_lo: 5, vs_hi: 6,
               hpol: 1'b1, vpol: 1'b1, fmod: 4, on: 1'b0, dr: 1'b0, ls: 1'b0, fs: 1'b0, k: 0, fc: 0};
        mb = '{ht: 800, vt: 525, hvis: 640, hs_lo: 656, hs_hi: 751, vvis: 480, vs_lo: 490, vs_hi: 491,
               hpol: 1'b0, vpol: 1'b0, fmod: 65536, on: 1'b0, dr: 1'b0, ls: 1'b0, fs: 1'b0, k: 0, fc: 0};
        rst       = 1'b1;
        ia.pix_en = 1'b0;
        ia.run    = 1'b0;
        ib.pix_en = 1'b0;
        ib.run    = 1'b0;
        @(posedge clk);
        #3;

        repeat (3) tick(1'b1, 1'b1, 1'b1);               // reset wins over run/pix_en
        repeat (5) tick(1'b1, 1'b0, 1'b0);               // stays idle without run
        repeat (250) tick(1'b1, 1'b1, 1'b0);             // continuous raster, two-plus frames
        for (int i = 0; i < 240; i++) tick(i % 4 == 3, 1'b1, 1'b0);  // pix_en every 4th clock
        repeat (250) tick(1'b1, 1'b0, 1'b0);             // stop mid-frame, drain to idle
        repeat (4) tick(1'b0, 1'b1, 1'b0);               // run without pix_en: no start
        repeat (60) tick(1'b1, 1'b1, 1'b0);
        repeat (5) tick(1'b1, 1'b0, 1'b0);               // brief run drop, resumed in-frame
        repeat (200) tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) tick((i % 3) != 1, 1'b0, 1'b0);  // drain with gapped pix_en
        repeat (50) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);                          // mid-frame reset
        repeat (500) tick(1'b1, 1'b1, 1'b0);             // four-plus frames, 2-bit count wraps
        repeat (2) tick(1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d/%0d pending required=0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
